// File: rtl/rr_arbiter_16_if.sv
// Handshake bundle between sixteen requesters and the round-robin arbiter.
// Latency: none (wires only).
// Backpressure: none; requesters hold req until served or they give up.
//
// Signals:
//   en        arbiter enable (requester side drives)
//   req[15:0] request vector, bit i = requester i
//   gnt[15:0] registered one-hot grant
//   gnt_idx   registered owner index, meaningful only with gnt_valid
//   gnt_valid live-grant flag
//   preempt   one-cycle pulse when the owner is revoked by the hold limit
interface rr_arbiter_16_if;
  logic        en;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        preempt;

  // Requester / bench side.
  modport master (
    output en, req,
    input  gnt, gnt_idx, gnt_valid, preempt
  );

  // Arbiter side.
  modport slave (
    input  en, req,
    output gnt, gnt_idx, gnt_valid, preempt
  );
endinterface

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters with an optional per-owner hold limit.
// Latency: grant appears one cycle after the requesting edge; all outputs registered.
// Backpressure: none; a request that drops before being granted is simply forgotten.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   arb  slave modport of rr_arbiter_16_if (en, req in; gnt, gnt_idx, gnt_valid, preempt out)
// Parameters:
//   MAX_HOLD  max consecutive grant cycles per owner, 0 = unlimited
//   HOLD_W    hold counter width, must satisfy MAX_HOLD <= 2**HOLD_W - 1
module rr_arbiter_16 #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic           clk,
  input  logic           rst,
  rr_arbiter_16_if.slave arb
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // Counter value on the owner's final permitted cycle.
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  logic [0:0]        state_q,     state_d;
  logic [3:0]        rr_ptr_q,    rr_ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
  logic [15:0]       gnt_q,       gnt_d;
  logic [3:0]        gnt_idx_q,   gnt_idx_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              preempt_q,   preempt_d;

  logic [3:0]  owner;
  logic [3:0]  owner_next;
  logic [15:0] others;
  logic        timeout;

  // First set bit of v, scanning upward from p and wrapping past 15 to 0.
  function automatic logic [3:0] pick(input logic [15:0] v, input logic [3:0] p);
    logic [3:0] idx;
    logic [3:0] res;
    logic       found;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      idx = p + 4'(k);
      if (!found && v[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign owner      = gnt_idx_q;
  assign owner_next = owner + 4'd1;
  assign others     = arb.req & ~(16'd1 << owner);
  assign timeout    = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    preempt_d   = 1'b0;

    if (state_q == IDLE) begin
      if (arb.en && (|arb.req)) begin
        state_d     = GRANT;
        gnt_idx_d   = pick(arb.req, rr_ptr_q);
        gnt_valid_d = 1'b1;
        hold_cnt_d  = '0;
      end else begin
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
      end
    end else begin
      // Priority: disable beats release, release beats timeout.
      if (!arb.en) begin
        state_d     = IDLE;
        rr_ptr_d    = owner_next;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = '0;
      end else if (!arb.req[owner]) begin
        rr_ptr_d = owner_next;
        if (|others) begin
          gnt_idx_d  = pick(others, owner_next);
          hold_cnt_d = '0;
        end else begin
          state_d     = IDLE;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
        end
      end else if (timeout) begin
        // A sole requester is re-granted; the pulse still marks the revocation.
        preempt_d  = 1'b1;
        rr_ptr_d   = owner_next;
        hold_cnt_d = '0;
        if (|others) begin
          gnt_idx_d = pick(others, owner_next);
        end
      end else if (hold_cnt_q != {HOLD_W{1'b1}}) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end

    gnt_d = gnt_valid_d ? (16'd1 << gnt_idx_d) : 16'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
    end
  end

  assign arb.gnt       = gnt_q;
  assign arb.gnt_idx   = gnt_idx_q;
  assign arb.gnt_valid = gnt_valid_q;
  assign arb.preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Bench for rr_arbiter_16: directed vector table plus hand sequences and a random run.
// Latency: n/a.
// Backpressure: n/a.
module tb_rr_arbiter_16;

  logic clk;
  logic rst;

  rr_arbiter_16_if if8 ();
  rr_arbiter_16_if if4 ();

  rr_arbiter_16 #(.MAX_HOLD(8), .HOLD_W(4)) dut8 (.clk(clk), .rst(rst), .arb(if8.slave));
  rr_arbiter_16 #(.MAX_HOLD(4), .HOLD_W(4)) dut4 (.clk(clk), .rst(rst), .arb(if4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        en;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  idx;
    logic        vld;
    logic        pre;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [15:0] g, input logic [3:0] i,
                      input logic v, input logic p);
    chk({tag, "_gnt"},  32'(if8.gnt),       32'(g));
    chk({tag, "_idx"},  32'(if8.gnt_idx),   32'(i));
    chk({tag, "_vld"},  32'(if8.gnt_valid), 32'(v));
    chk({tag, "_pre"},  32'(if8.preempt),   32'(p));
  endtask

  initial begin
    logic [15:0] req_applied;
    logic        pv;
    logic [3:0]  pidx;
    int          run;
    int          o;

    rst = 1'b1;
    if8.en = 1'b0; if8.req = '0;
    if4.en = 1'b0; if4.req = '0;

    // rr_ptr starts at 0; expected outputs are those seen just after each edge.
    vecs[0]  = '{1'b0, 16'hFFFF, 16'h0000, 4'd0,  1'b0, 1'b0}; // disabled
    vecs[1]  = '{1'b1, 16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0}; // no requests
    vecs[2]  = '{1'b1, 16'h0010, 16'h0010, 4'd4,  1'b1, 1'b0}; // first grant
    vecs[3]  = '{1'b1, 16'h0010, 16'h0010, 4'd4,  1'b1, 1'b0}; // hold
    vecs[4]  = '{1'b1, 16'h0108, 16'h0100, 4'd8,  1'b1, 1'b0}; // release 4, search from 5
    vecs[5]  = '{1'b1, 16'h0008, 16'h0008, 4'd3,  1'b1, 1'b0}; // release 8, wrap to 3
    vecs[6]  = '{1'b1, 16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0}; // release to idle, ptr=4
    vecs[7]  = '{1'b1, 16'h0009, 16'h0001, 4'd0,  1'b1, 1'b0}; // from 4: wrap to 0
    vecs[8]  = '{1'b0, 16'h0009, 16'h0000, 4'd0,  1'b0, 1'b0}; // disable, ptr=1
    vecs[9]  = '{1'b1, 16'h0009, 16'h0008, 4'd3,  1'b1, 1'b0}; // from 1 -> 3
    vecs[10] = '{1'b1, 16'h8008, 16'h0008, 4'd3,  1'b1, 1'b0}; // hold 3
    vecs[11] = '{1'b1, 16'h8000, 16'h8000, 4'd15, 1'b1, 1'b0}; // back-to-back to 15
    vecs[12] = '{1'b1, 16'h8001, 16'h8000, 4'd15, 1'b1, 1'b0}; // hold 15
    vecs[13] = '{1'b1, 16'h0001, 16'h0001, 4'd0,  1'b1, 1'b0}; // 15 releases, wrap to 0
    vecs[14] = '{1'b1, 16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0}; // idle, ptr=1

    repeat (2) @(posedge clk);
    #1;
    chk8("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      if8.en  = vecs[i].en;
      if8.req = vecs[i].req;
      tick();
      chk8($sformatf("v%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].vld, vecs[i].pre);
    end

    // Enable drop during owner 3 advances the pointer past 3.
    if8.en = 1'b1; if8.req = 16'h0018;
    tick(); chk8("en_a", 16'h0008, 4'd3, 1'b1, 1'b0);
    if8.en = 1'b0;
    tick(); chk8("en_b", 16'h0000, 4'd0, 1'b0, 1'b0);
    if8.en = 1'b1;
    tick(); chk8("en_c", 16'h0010, 4'd4, 1'b1, 1'b0);
    if8.req = 16'h0000;
    tick(); chk8("en_d", 16'h0000, 4'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a grant, away from any clock edge.
    if8.req = 16'h0040;
    tick(); chk8("pre_rst", 16'h0040, 4'd6, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt", 32'(if8.gnt),       32'h0);
    chk("arst_vld", 32'(if8.gnt_valid), 32'h0);
    chk("arst_pre", 32'(if8.preempt),   32'h0);
    if8.req = 16'h0001;
    #1 rst = 1'b0;
    tick(); chk8("post_rst", 16'h0001, 4'd0, 1'b1, 1'b0);

    // Fairness: owner 0 already holds (cycle 1); all 16 then request.
    if8.req = 16'hFFFF;
    for (int k = 2; k <= 136; k++) begin
      tick();
      o = ((k - 1) / 8) % 16;
      chk($sformatf("fair%0d_idx", k), 32'(if8.gnt_idx),   32'(o));
      chk($sformatf("fair%0d_vld", k), 32'(if8.gnt_valid), 32'h1);
      chk($sformatf("fair%0d_pre", k), 32'(if8.preempt),   32'(((k - 1) % 8) == 0));
    end
    if8.req = 16'h0000;
    tick();

    // Sole requester under a 4-cycle limit: re-granted with a preempt pulse.
    if4.en = 1'b1; if4.req = 16'h0020;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("sole%0d_gnt", k), 32'(if4.gnt),     32'h0020);
      chk($sformatf("sole%0d_idx", k), 32'(if4.gnt_idx), 32'd5);
      chk($sformatf("sole%0d_pre", k), 32'(if4.preempt), 32'(k > 1 && ((k - 1) % 4) == 0));
    end
    if4.en = 1'b0; if4.req = '0;
    tick();

    // Random traffic with invariant checks.
    pv = 1'b0; pidx = '0; run = 0; req_applied = '0;
    for (int c = 0; c < 10000; c++) begin
      if8.en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 3) == 0) req_applied = 16'($urandom) & 16'($urandom);
      if8.req = req_applied;
      tick();
      chk("inv_map", 32'(if8.gnt),
          32'(if8.gnt_valid ? (16'd1 << if8.gnt_idx) : 16'd0));
      chk("inv_onehot", 32'($countones(if8.gnt) <= 1), 32'h1);
      if (if8.gnt_valid) begin
        if (!pv || if8.gnt_idx != pidx || if8.preempt) begin
          chk("inv_req_at_grant", 32'(req_applied[if8.gnt_idx]), 32'h1);
          run = 1;
        end else begin
          run++;
        end
        chk("inv_hold", 32'(run <= 8), 32'h1);
      end else begin
        run = 0;
      end
      pv   = if8.gnt_valid;
      pidx = if8.gnt_idx;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
